// File: rtl/boot_rd_pkg.sv
// Shared types for the boot read sequencer: FSM encoding, return-path tag and
// index-width helper.
package boot_rd_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_BOOT_RD   = 3'd0;
    localparam state_t ST_BOOT_WAIT = 3'd1;
    localparam state_t ST_IDLE      = 3'd2;
    localparam state_t ST_USR_RD    = 3'd3;
    localparam state_t ST_USR_WAIT  = 3'd4;

    // Tag index is sized for the largest supported burst (256 boot words).
    localparam int TAG_IDX_W = 8;

    typedef struct packed {
        logic                 boot;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

    function automatic int IDX_W(input int boot_rds);
        return (boot_rds > 1) ? $clog2(boot_rds) : 1;
    endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Valid/tag delay line matching the memory read latency; the output marks the
// cycle in which rdata belongs to the tagged read.
module rd_lat_pipe
    import boot_rd_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  tag_t in_tag,
    output logic out_valid,
    output tag_t out_tag
);

    logic valid_reg [RD_LAT+1];
    tag_t tag_reg   [RD_LAT+1];

    assign valid_reg[0] = in_valid;
    assign tag_reg[0]   = in_tag;

    generate
        for (genvar gi = 1; gi <= RD_LAT; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[gi] <= 1'b0;
                    tag_reg[gi]   <= '0;
                end else begin
                    valid_reg[gi] <= valid_reg[gi-1];
                    tag_reg[gi]   <= tag_reg[gi-1];
                end
            end
        end
    endgenerate

    assign out_valid = valid_reg[RD_LAT];
    assign out_tag   = tag_reg[RD_LAT];

endmodule

// File: rtl/boot_read_sequencer.sv
// Memory read master: automatic boot burst into cfg_word after reset, then
// single user reads over a req/gnt/valid handshake.
module boot_read_sequencer
    import boot_rd_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int BOOT_RDS  = 2,
    parameter int BOOT_BASE = 0,
    parameter int RD_LAT    = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       rd,
    output logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          rdata,
    output logic                       boot_done,
    output logic [BOOT_RDS*DATA_W-1:0] cfg_word,
    input  logic                       usr_req,
    input  logic [ADDR_W-1:0]          usr_addr,
    output logic                       usr_gnt,
    output logic [DATA_W-1:0]          usr_rdata,
    output logic                       usr_valid
);

    localparam int                CNT_W    = IDX_W(BOOT_RDS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BOOT_RDS - 1);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BOOT_BASE);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg;
    logic [ADDR_W-1:0]   usr_addr_reg;
    logic                boot_done_reg, usr_gnt_reg, usr_valid_reg;
    logic [DATA_W-1:0]   usr_rdata_reg;
    logic [DATA_W-1:0]   cfg_reg [BOOT_RDS];

    logic                ret_valid;
    tag_t                ret_tag, issue_tag;
    logic                ret_boot, ret_usr, ret_last;

    // rd decodes straight from rst_n so the burst starts on the first edge.
    assign rd = rst_n & ((state_reg == ST_BOOT_RD) | (state_reg == ST_USR_RD));

    always_comb begin
        addr = '0;
        if (state_reg == ST_BOOT_RD)
            addr = BASE_A + ADDR_W'(cnt_reg);
        else if (state_reg == ST_USR_RD)
            addr = usr_addr_reg;
    end

    assign issue_tag.boot = (state_reg == ST_BOOT_RD);
    assign issue_tag.idx  = TAG_IDX_W'(cnt_reg);

    rd_lat_pipe #(.RD_LAT(RD_LAT)) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (rd),
        .in_tag   (issue_tag),
        .out_valid(ret_valid),
        .out_tag  (ret_tag)
    );

    assign ret_boot = ret_valid & ret_tag.boot;
    assign ret_usr  = ret_valid & ~ret_tag.boot;
    assign ret_last = ret_boot & (ret_tag.idx == TAG_IDX_W'(BOOT_RDS - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_BOOT_RD:   if (cnt_reg == CNT_LAST) state_next = ST_BOOT_WAIT;
            ST_BOOT_WAIT: if (ret_last)            state_next = ST_IDLE;
            ST_IDLE:      if (usr_req)             state_next = ST_USR_RD;
            ST_USR_RD:                             state_next = ST_USR_WAIT;
            ST_USR_WAIT:  if (ret_usr)             state_next = ST_IDLE;
            default:                               state_next = ST_BOOT_RD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_BOOT_RD;
            cnt_reg       <= '0;
            usr_addr_reg  <= '0;
            boot_done_reg <= 1'b0;
            usr_gnt_reg   <= 1'b0;
            usr_valid_reg <= 1'b0;
            usr_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            usr_gnt_reg   <= 1'b0;
            usr_valid_reg <= 1'b0;
            if (state_reg == ST_BOOT_RD && cnt_reg != CNT_LAST)
                cnt_reg <= cnt_reg + CNT_W'(1);
            if (state_reg == ST_BOOT_WAIT && ret_last)
                boot_done_reg <= 1'b1;
            if (state_reg == ST_IDLE && usr_req) begin
                usr_gnt_reg  <= 1'b1;
                usr_addr_reg <= usr_addr;
            end
            if (state_reg == ST_USR_WAIT && ret_usr) begin
                usr_rdata_reg <= rdata;
                usr_valid_reg <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < BOOT_RDS; gi++) begin : g_cfg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    cfg_reg[gi] <= '0;
                else if (ret_boot && ret_tag.idx == TAG_IDX_W'(gi))
                    cfg_reg[gi] <= rdata;
            end
            assign cfg_word[gi*DATA_W +: DATA_W] = cfg_reg[gi];
        end
    endgenerate

    assign boot_done = boot_done_reg;
    assign usr_gnt   = usr_gnt_reg;
    assign usr_valid = usr_valid_reg;
    assign usr_rdata = usr_rdata_reg;

endmodule
